// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the PC fetch sequencer: state encoding, PC constants
// and the ripple-carry adder used for next-PC arithmetic.
package pc_fetch_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [31:0] PC_INCR         = 32'd4;
   localparam int          JUMP_REGION_MSB = 31;
   localparam int          JUMP_REGION_LSB = 28;

   // Bit-serial ripple-carry sum, modulo 2^32; the carry-out is dropped.
   function automatic logic [31:0] ripple_add32(input logic [31:0] a, input logic [31:0] b);
      logic        carry;
      logic [31:0] sum;
      carry = 1'b0;
      sum   = '0;
      for (int i = 0; i < 32; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      return sum;
   endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Bundles the instruction-memory fetch bus and the decode handshake of the
// PC fetch sequencer; master is the sequencer, slave is memory plus decode.
interface pc_fetch_sequencer_if;
   logic               imem_req;
   logic        [31:0] imem_addr;
   logic               imem_ack;
   logic        [31:0] imem_rdata;
   logic        [31:0] instr;
   logic               instr_valid;
   logic        [31:0] pc;
   logic        [31:0] pc_plus4;
   logic               advance;
   logic               stall;
   logic               branch_taken;
   logic signed [31:0] branch_offset;
   logic               jump;
   logic        [25:0] jump_target;

   modport master (
      output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4,
      input  imem_ack, imem_rdata, advance, stall, branch_taken,
             branch_offset, jump, jump_target
   );

   modport slave (
      input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4,
      output imem_ack, imem_rdata, advance, stall, branch_taken,
             branch_offset, jump, jump_target
   );
endinterface

// File: rtl/pc_fetch_sequencer_pc_next_calc.sv
// Combinational next-PC logic: pc+4, branch target and jump target, with
// jump taking priority over a taken branch.
module pc_next_calc
   import pc_fetch_sequencer_pkg::*;
(
   input  logic               [31:0] pc,
   input  logic                      branch_taken,
   input  logic signed        [31:0] branch_offset,
   input  logic                      jump,
   input  logic               [25:0] jump_target,
   output logic               [31:0] pc_plus4,
   output logic               [31:0] next_pc
);

   logic signed [31:0] offset_bytes;
   logic        [31:0] branch_target;
   logic        [31:0] jump_dest;

   // Word offset scaled to bytes; the top two offset bits fall off, matching modulo-2^32 arithmetic.
   assign offset_bytes  = branch_offset <<< 2;
   assign pc_plus4      = ripple_add32(pc, PC_INCR);
   assign branch_target = ripple_add32(pc_plus4, $unsigned(offset_bytes));
   assign jump_dest     = {pc_plus4[JUMP_REGION_MSB:JUMP_REGION_LSB], jump_target, 2'b00};

   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = jump_dest;
      end else if (branch_taken) begin
         next_pc = branch_target;
      end
   end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program-counter stage: fetches the word at pc over req/ack, holds it for
// decode until an unstalled advance, then steps pc to the computed next PC.
module pc_fetch_sequencer
   import pc_fetch_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
)
(
   input  logic                  clk,
   input  logic                  reset_n,
   pc_fetch_sequencer_if.master  bus
);

   state_t      state;
   logic [31:0] pc_cur;
   logic [31:0] instr_buf;
   logic        req;
   logic        valid;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic        accept;

   assign accept = bus.advance && !bus.stall;

   pc_next_calc u_next (
      .pc            (pc_cur),
      .branch_taken  (bus.branch_taken),
      .branch_offset (bus.branch_offset),
      .jump          (bus.jump),
      .jump_target   (bus.jump_target),
      .pc_plus4      (pc_plus4),
      .next_pc       (next_pc)
   );

   // Async reset drops req/valid immediately, abandoning any fetch in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         pc_cur    <= RESET_VECTOR;
         instr_buf <= '0;
         req       <= 1'b0;
         valid     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= FETCH;
               req   <= 1'b1;
            end
            FETCH: begin
               if (bus.imem_ack) begin
                  instr_buf <= bus.imem_rdata;
                  valid     <= 1'b1;
                  req       <= 1'b0;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (accept) begin
                  pc_cur <= next_pc;
                  valid  <= 1'b0;
                  req    <= 1'b1;
                  state  <= FETCH;
               end
            end
            default: begin
               state <= IDLE;
               req   <= 1'b0;
               valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req    = req;
   assign bus.imem_addr   = pc_cur;
   assign bus.instr       = instr_buf;
   assign bus.instr_valid = valid;
   assign bus.pc          = pc_cur;
   assign bus.pc_plus4    = pc_plus4;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Randomized and directed bench for pc_fetch_sequencer against a
// transaction-level model of fetch/hold behaviour and next-PC rules.
module tb_pc_fetch_sequencer;

   logic clk;
   logic reset_n;

   pc_fetch_sequencer_if bus ();
   pc_fetch_sequencer_if wbus ();

   pc_fetch_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   pc_fetch_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_wrap (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (wbus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model: awaiting first edge after reset, fetch outstanding, instruction held.
   logic        m_boot;
   logic        m_fetching;
   logic        m_holding;
   logic [31:0] m_pc;
   logic [31:0] m_instr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic br,
                                            input logic [31:0] off, input logic jmp,
                                            input logic [25:0] tgt);
      logic [31:0] seq;
      seq = cur + 32'd4;
      if (jmp) return {seq[31:28], tgt, 2'b00};
      if (br)  return seq + off * 32'd4;
      return seq;
   endfunction

   task automatic model_reset();
      m_boot     = 1'b1;
      m_fetching = 1'b0;
      m_holding  = 1'b0;
      m_pc       = 32'h0;
      m_instr    = 32'h0;
   endtask

   task automatic check_outputs();
      chk("imem_req", {31'b0, bus.imem_req}, {31'b0, m_fetching});
      chk("instr_valid", {31'b0, bus.instr_valid}, {31'b0, m_holding});
      chk("pc", bus.pc, m_pc);
      chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
      chk("instr", bus.instr, m_instr);
      if (m_fetching) chk("imem_addr", bus.imem_addr, m_pc);
   endtask

   // One clock: check at negedge, drive, take the edge, update the model, return at negedge.
   task automatic step(input logic ack, input logic adv, input logic stl, input logic br,
                       input logic [31:0] off, input logic jmp, input logic [25:0] tgt,
                       input logic [31:0] rd);
      check_outputs();
      bus.imem_ack      = ack;
      bus.advance       = adv;
      bus.stall         = stl;
      bus.branch_taken  = br;
      bus.branch_offset = off;
      bus.jump          = jmp;
      bus.jump_target   = tgt;
      bus.imem_rdata    = rd;
      @(posedge clk);
      if (reset_n) begin
         if (m_boot) begin
            m_boot     = 1'b0;
            m_fetching = 1'b1;
         end else if (m_fetching) begin
            if (ack) begin
               m_instr    = rd;
               m_fetching = 1'b0;
               m_holding  = 1'b1;
            end
         end else if (m_holding && adv && !stl) begin
            m_pc       = ref_next(m_pc, br, off, jmp, tgt);
            m_holding  = 1'b0;
            m_fetching = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_step();
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0);
   endtask

   task automatic ack_step(input logic [31:0] rd);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, rd);
   endtask

   task automatic adv_step(input logic br, input logic [31:0] off, input logic jmp,
                           input logic [25:0] tgt);
      step(1'b0, 1'b1, 1'b0, br, off, jmp, tgt, 32'h0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset_n = 1'b1;
      bus.imem_ack = 1'b0;
      model_reset();
   endtask

   initial begin
      reset_n = 1'b0;
      bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.advance = 1'b0; bus.stall = 1'b0;
      bus.branch_taken = 1'b0; bus.branch_offset = '0; bus.jump = 1'b0; bus.jump_target = '0;
      wbus.imem_ack = 1'b1; wbus.imem_rdata = 32'hCAFE_0001; wbus.advance = 1'b1;
      wbus.stall = 1'b0; wbus.branch_taken = 1'b0; wbus.branch_offset = '0;
      wbus.jump = 1'b0; wbus.jump_target = '0;
      model_reset();
      repeat (3) @(posedge clk);
      release_reset();

      // Reset state and sequential fetch 0x0, 0x4, 0x8; wrap-vector instance rides along
      chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
      idle_step();
      chk("wrap_addr", wbus.imem_addr, 32'hFFFF_FFFC);
      chk("wrap_p4_fetch", wbus.pc_plus4, 32'h0);
      for (int i = 0; i < 3; i++) begin
         chk("seq_addr", bus.imem_addr, 32'(i * 4));
         ack_step(32'h1000_0000 + 32'(i));
         if (i == 0) begin
            chk("wrap_valid", {31'b0, wbus.instr_valid}, 32'd1);
            chk("wrap_p4_hold", wbus.pc_plus4, 32'h0);
         end
         chk("seq_valid", {31'b0, bus.instr_valid}, 32'd1);
         adv_step(1'b0, 32'h0, 1'b0, 26'h0);
         if (i == 0) chk("wrap_next_addr", wbus.imem_addr, 32'h0);
      end
      ack_step(32'hAAAA_0003);
      adv_step(1'b0, 32'h0, 1'b0, 26'h0);

      // Wait states at 0x10, then stalled advance
      for (int i = 0; i < 3; i++) begin
         chk("wait_addr", bus.imem_addr, 32'h10);
         idle_step();
      end
      ack_step(32'hBEEF_0010);
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0);
         chk("stall_pc", bus.pc, 32'h10);
         chk("stall_instr", bus.instr, 32'hBEEF_0010);
      end
      adv_step(1'b0, 32'h0, 1'b0, 26'h0);
      chk("post_stall_addr", bus.imem_addr, 32'h14);

      // Branches from 0x100: backward by 2 words, forward by 3 words
      ack_step(32'h1);
      adv_step(1'b0, 32'h0, 1'b1, 26'h40);
      chk("jump_to_100", bus.pc, 32'h100);
      ack_step(32'h2);
      adv_step(1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0);
      chk("branch_back", bus.imem_addr, 32'hFC);
      ack_step(32'h3);
      adv_step(1'b0, 32'h0, 1'b1, 26'h40);
      ack_step(32'h4);
      adv_step(1'b1, 32'h3, 1'b0, 26'h0);
      chk("branch_fwd", bus.imem_addr, 32'h110);

      // Reach 0x4000_0000 by branch, then jump beats branch
      ack_step(32'h5);
      adv_step(1'b1, 32'h0FFF_FFBB, 1'b0, 26'h0);
      chk("far_branch", bus.pc, 32'h4000_0000);
      ack_step(32'h6);
      adv_step(1'b1, 32'h0000_0100, 1'b1, 26'h40);
      chk("jump_priority", bus.imem_addr, 32'h4000_0100);

      // Random traffic, including inputs presented outside their active state
      for (int n = 0; n < 300; n++) begin
         step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
              $urandom_range(0, 2) == 0, 32'($signed($urandom_range(0, 64)) - 32),
              $urandom_range(0, 4) == 0, 26'($urandom), $urandom);
      end

      // Reset while FETCH has an ack arriving
      idle_step();
      adv_step(1'b0, 32'h0, 1'b0, 26'h0);
      chk("pre_rst_fetch", {31'b0, bus.imem_req}, 32'd1);
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_fetch_req", {31'b0, bus.imem_req}, 32'd0);
      chk("rst_fetch_valid", {31'b0, bus.instr_valid}, 32'd0);
      @(posedge clk);
      #1 chk("rst_ack_ignored", {31'b0, bus.instr_valid}, 32'd0);
      release_reset();
      idle_step();
      chk("restart_addr", bus.imem_addr, 32'h0);
      ack_step(32'h7777_0000);

      // Reset while HOLD
      chk("pre_rst_hold", {31'b0, bus.instr_valid}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_hold_valid", {31'b0, bus.instr_valid}, 32'd0);
      chk("rst_hold_instr", bus.instr, 32'd0);
      chk("rst_hold_pc", bus.pc, 32'd0);
      release_reset();
      for (int n = 0; n < 40; n++) begin
         step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
              $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) == 0,
              26'($urandom), $urandom);
      end
      check_outputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Program-counter stage that holds the 32-bit PC, fetches instructions over a req/ack handshake, and computes the next PC.
- Sits directly upstream of the 32-bit adder datapath. It supplies the PC operand and consumes the adder result for PC+4 and branch-target generation.
- Hands each fetched instruction to decode with a valid/advance handshake.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address; equals pc while imem_req=1
imem_ack  input  1  memory has returned imem_rdata this cycle
imem_rdata  input  32  instruction word
instr  output  32  latched instruction for decode
instr_valid  output  1  instr holds a fetched, unconsumed instruction
pc  output  32  address of the current instruction
pc_plus4  output  32  pc + 4 (for link/branch use)
advance  input  1  decode consumes instr this cycle
stall  input  1  hazard hold; blocks advance
branch_taken  input  1  take conditional branch on this advance
branch_offset  input  32  sign-extended word offset
jump  input  1  take absolute jump on this advance
jump_target  input  26  jump index field

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, asynchronous and active-low.
- Reset values, applied immediately when reset_n falls, regardless of state:
  - pc=RESET_VECTOR, state=IDLE, imem_req=0, instr_valid=0, instr=0.
  - An in-flight fetch is abandoned. imem_ack arriving during or after reset is ignored.
- States:
  - IDLE: entered only from reset. Moves to FETCH on the first clock edge with reset_n=1.
  - FETCH: imem_req=1 and imem_addr=pc, held stable until ack.
    - On a cycle with imem_ack=1: instr<=imem_rdata and instr_valid<=1 at that edge; next state is HOLD.
    - Without ack: stay in FETCH, no timeout.
    - Minimum latency from entering FETCH to instr_valid=1 is 1 cycle (ack in the first FETCH cycle).
  - HOLD: imem_req=0, instr_valid=1.
    - Accepted advance = advance=1 and stall=0.
    - On an accepted advance: pc<=next_pc, instr_valid<=0, next state FETCH.
    - Otherwise instr, pc and instr_valid are held.
- Next-PC priority (evaluated only on an accepted advance):
  - jump: next_pc={pc_plus4[31:28], jump_target, 2'b00}. Jump wins if jump and branch_taken are both high.
  - branch_taken: next_pc=pc_plus4 + (branch_offset<<2).
  - otherwise: next_pc=pc_plus4.
- Arithmetic: all sums are 32-bit modulo 2^32 with carry-out discarded. pc=32'hFFFF_FFFC gives pc_plus4=0.
- pc_plus4 is combinational from pc and valid in every state.
- Ignored inputs:
  - imem_ack outside FETCH.
  - advance, stall, branch_taken and jump outside HOLD.
  - advance with stall=1 (no state change).
- instr_valid never rises without a corresponding ack. Each ack produces exactly one instr_valid episode.

Decomposition:
- Shared package:
  - state encoding constants IDLE=2'd0, FETCH=2'd1, HOLD=2'd2 (2'd3 is illegal and recovers to IDLE).
  - PC_INCR=32'd4.
  - JUMP_REGION_MSB=31 and JUMP_REGION_LSB=28.
- One combinational sub-module, pc_next_calc. It takes pc, branch_taken, branch_offset, jump and jump_target, and returns pc_plus4 and next_pc.
  - It uses the team's existing 32-bit ripple adder twice: pc+4, and pc_plus4+shifted offset.
  - The FSM and registers stay in pc_fetch_sequencer.

Test Plan:
- Reset and sequential fetch: release reset_n with RESET_VECTOR=0; ack each FETCH in its first cycle and pulse advance → imem_addr sequence 0x0, 0x4, 0x8. instr_valid rises 1 cycle after each FETCH entry. pc_plus4 = pc+4 throughout.
- Wait states and stall: delay ack 3 cycles → imem_req and imem_addr hold at 0x10 for 3 cycles with instr_valid=0. Then stall=1 with advance=1 for 2 cycles → pc stays 0x10 and instr stays constant. Release stall → next fetch at 0x14.
- Branch: pc=0x100, branch_taken=1, branch_offset=32'hFFFF_FFFE → next fetch at 0x104-8=0xFC. Repeat with offset 3 → 0x110.
- Jump priority: pc=0x4000_0000, jump=1, jump_target=26'h000_0040, branch_taken=1 → next fetch at 0x4000_0100.
- Wrap-around: RESET_VECTOR=32'hFFFF_FFFC; ack and advance once → pc_plus4=0 before advance, next imem_addr=0x0000_0000.
- Reset mid-operation: assert reset_n=0 while in FETCH with ack pending, and again in HOLD → imem_req and instr_valid drop to 0 in the same cycle, before the next clock edge. After release, the first fetch is at RESET_VECTOR. An ack delivered during reset produces no instr_valid.
